ecall_io_unit: RTL and testbench
================================

# ecall_io_unit

Services `ECALL` instructions for the single-cycle RISC-V core by talking to the board's switches, confirm button and seven-segment tube. It sits beside the register file:
- Input services: stalls the core via `stop_flag` until the user confirms, then supplies the value for a0 on `io_data` and pulses the write-back cycle.
- Output and exit services: latch a0 for display, or halt the core.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles the synchronized button level must differ from the stable level before the stable level flips (10 ms at 100 MHz). Valid range 2..2^20-1; the counter is 20 bits.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low.
- `ecall_valid` in 1: the current instruction is `ECALL`; held high while `stop_flag` freezes the PC.
- `a7` in 32: service code, taken from register x17.
- `a0` in 32: argument, taken from register x10.
- `switches` in 16: raw board switches. They are asynchronous.
- `confirm_btn` in 1: raw confirm push-button, active-high. It is asynchronous.
- `stop_flag` out 1: stalls the PC and register-file writes.
- `io_data` out 32: value for a0 (the register file's `W_data_io`).
- `io_wr_en` out 1: write-back cycle marker, high for exactly one cycle.
- `disp_data` out 32: value shown on the tube.
- `led_busy` out 1: high while waiting for the user.

## Operation
Service codes:
- 5: READ_INT. Result = sign-extended `switches[15:0]`.
- 12: READ_CHAR. Result = zero-extended `switches[7:0]`.
- 1: PRINT_INT. `disp_data` <= a0.
- 10: EXIT. Halt the core.
- Any other code: no-op. No stall, no state change.

Input path:
- `confirm_btn` and `switches` each pass through a 2-flop synchronizer.
- The button then passes through the debouncer. `cnt` counts while the synchronized level differs from `stable`.
- When the levels differ and `cnt == DEBOUNCE_CYCLES-1`: `stable` <= synchronized level and `cnt` <= 0.
- When the levels are equal: `cnt` <= 0.
- `press` = `stable` & ~`stable_q`, a one-cycle pulse on the debounced rising edge.

FSM states: IDLE, WAIT_PRESS, WRITEBACK, HALT.
- IDLE:
  - `ecall_valid` with code 5 or 12 -> WAIT_PRESS. The service is latched into `svc`.
  - Code 1: `disp_data` <= a0 at this edge; stay in IDLE.
  - Code 10 -> HALT.
- WAIT_PRESS: on `press`, `io_data` <= result per `svc` from the synchronized switches, then -> WRITEBACK. Without `press`, stay in WAIT_PRESS.
- WRITEBACK: `io_wr_en`=1 and `stop_flag`=0, so the register file writes a0 and the PC advances at this edge. `ecall_valid` is ignored in this state. Next state is IDLE unconditionally.
- HALT: absorbing. Only reset leaves it.

Output equations:
- `stop_flag` = (IDLE & `ecall_valid` & a7∈{5,12,10}) | WAIT_PRESS | HALT. The IDLE term is combinational, so the stall applies in the ecall's first cycle.
- `led_busy` = WAIT_PRESS.

## Timing
- Reset values: state=IDLE; `stop_flag`=0 (absent `ecall_valid`); `io_data`=0; `io_wr_en`=0; `disp_data`=0; `led_busy`=0; synchronizers, `stable`, `stable_q` and `cnt` all 0.
- Press latency (D=`DEBOUNCE_CYCLES`): raw button first sampled high at edge E0 and held.
  - Synchronized level high after E1.
  - `stable` rises at E(D+1); `press` is high in the following cycle.
  - FSM enters WRITEBACK at E(D+2).
  - Register write and return to IDLE at E(D+3).
- Glitches: a raw high shorter than D cycles after synchronization produces no `press`.
- Button already held when the ecall arrives: no `press` is generated. The user must release (debounced) and press again.
- Release debounce: release also needs D stable cycles before `stable` falls.
- PRINT_INT: no stall. `disp_data` updates at the ecall's edge.
- Back-to-back ecalls: the next ecall is handled from IDLE in the cycle after WRITEBACK.
- Reset mid-WAIT_PRESS or mid-HALT: immediate return to IDLE with all registers cleared; no `io_wr_en` is emitted.
- `switches` are sampled only at the `press` edge. Later changes do not affect `io_data`.

## Structure
- Package `ecall_io_pkg`:
  - Service-code constants SVC_PRINT_INT=1, SVC_READ_INT=5, SVC_EXIT=10, SVC_READ_CHAR=12.
  - FSM state encoding.
  - The `ECALL` opcode constant 7'b1110011.
- Sub-module `btn_debounce`:
  - Parameter `DEBOUNCE_CYCLES`.
  - Ports `clk`, `reset`, `raw`, `level`, `press`.
  - Contains the 2-flop synchronizer, the counter and the edge detect.
- The top level holds the FSM, the switch synchronizer and the output registers.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES`=4.
- READ_INT: a7=5, `switches`=16'hFFFE, button pressed for 10 cycles -> `stop_flag` high from the ecall cycle; `io_data`=32'hFFFF_FFFE with `io_wr_en`=1 for exactly one cycle at E0+6; `stop_flag` low in that cycle.
- READ_CHAR: a7=12, `switches`=16'h80C1, press -> `io_data`=32'h0000_00C1.
- Glitch rejection: a7=5, button high for 3 cycles then low -> no `press`; remains in WAIT_PRESS with `led_busy`=1; a subsequent 6-cycle press completes the read.
- Held button and PRINT_INT: button held before the ecall with a7=5 -> no completion until release plus re-press. Separately, a7=1, a0=32'h1234_5678 -> `disp_data`=32'h1234_5678 after one edge, with `stop_flag` never high.
- EXIT, unknown code and reset: a7=10 -> `stop_flag` stays 1 for 100 cycles regardless of the button; reset -> `stop_flag`=0 and `disp_data`=0. a7=7 -> no stall and no writes.
- Reset mid-wait: reset asserted during WAIT_PRESS -> IDLE and `io_wr_en` never pulses; the next ecall with a7=5 behaves normally.

Source files
------------

// File: rtl/ecall_io_unit_pkg.sv
// Shared constants, state encoding and helpers for the ECALL I/O unit.
package ecall_io_pkg;

    // Service codes carried in a7 (x17)
    localparam logic [31:0] SVC_PRINT_INT = 32'd1;
    localparam logic [31:0] SVC_READ_INT  = 32'd5;
    localparam logic [31:0] SVC_EXIT      = 32'd10;
    localparam logic [31:0] SVC_READ_CHAR = 32'd12;

    // RISC-V SYSTEM opcode used by ECALL
    localparam logic [6:0] ECALL_OPCODE = 7'b1110011;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_PRESS = 2'd1,
        ST_WRITEBACK  = 2'd2,
        ST_HALT       = 2'd3
    } state_t;

    // Which input service is pending while waiting for the user
    typedef enum logic {
        RD_INT  = 1'b0,
        RD_CHAR = 1'b1
    } rd_kind_t;

    // Value written back to a0 for an input service
    function automatic logic [31:0] read_result(rd_kind_t kind, logic [15:0] sw);
        if (kind == RD_CHAR) begin
            return {24'd0, sw[7:0]};
        end
        return {{16{sw[15]}}, sw};
    endfunction

endpackage

// File: rtl/ecall_io_unit_if.sv
// Core-side ECALL request / write-back signals.
interface ecall_io_unit_if;
    logic        ecall_valid;
    logic [31:0] a7;
    logic [31:0] a0;
    logic        stop_flag;
    logic [31:0] io_data;
    logic        io_wr_en;

    // Core (decoder + register file) side
    modport master (
        output ecall_valid, a7, a0,
        input  stop_flag, io_data, io_wr_en
    );

    // I/O unit side
    modport slave (
        input  ecall_valid, a7, a0,
        output stop_flag, io_data, io_wr_en
    );
endinterface

// File: rtl/ecall_io_unit_btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, counter debouncer and
// rising-edge detector on the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);
    // Last count value before the stable level is allowed to flip
    localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

    logic        sync1_q, sync2_q;
    logic        stable_q, stable_d;
    logic        stable_prev_q;
    logic [19:0] cnt_q, cnt_d;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Count how long the synchronized level disagrees with the stable level
    always_comb begin
        stable_d = stable_q;
        cnt_d    = 20'd0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                cnt_d    = 20'd0;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end
    end

    // Debouncer state and one-cycle-delayed copy for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= 20'd0;
        end else begin
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
        end
    end

    assign level = stable_q;
    assign press = stable_q & ~stable_prev_q;

endmodule

// File: rtl/ecall_io_unit.sv
// ECALL service unit: stalls the core for input services until the user
// confirms, writes the switch value back to a0, latches PRINT_INT values
// for the tube and halts the core on EXIT.
module ecall_io_unit
    import ecall_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    ecall_io_unit_if.slave        core,
    input  logic [15:0]           switches,
    input  logic                  confirm_btn,
    output logic [31:0]           disp_data,
    output logic                  led_busy
);
    logic [15:0] sw_sync1_q, sw_sync2_q;
    logic        btn_press;
    logic        unused_btn_level;

    state_t      state_q, state_d;
    rd_kind_t    kind_q, kind_d;
    logic [31:0] io_data_q, io_data_d;
    logic [31:0] disp_data_q, disp_data_d;
    logic        stop_flag, io_wr_en, busy;

    // The FSM only reacts to the press edge; the level is not needed here
    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk   (clk),
        .reset (reset),
        .raw   (confirm_btn),
        .level (unused_btn_level),
        .press (btn_press)
    );

    // Bring the asynchronous switches into the clock domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_sync1_q <= 16'd0;
            sw_sync2_q <= 16'd0;
        end else begin
            sw_sync1_q <= switches;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    // Next-state, result capture and stall/write-back decode
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        io_data_d   = io_data_q;
        disp_data_d = disp_data_q;
        stop_flag   = 1'b0;
        io_wr_en    = 1'b0;
        busy        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (core.ecall_valid) begin
                    if (core.a7 == SVC_READ_INT || core.a7 == SVC_READ_CHAR) begin
                        // Stall already in the ecall's first cycle
                        stop_flag = 1'b1;
                        state_d   = ST_WAIT_PRESS;
                        kind_d    = (core.a7 == SVC_READ_CHAR) ? RD_CHAR : RD_INT;
                    end else if (core.a7 == SVC_EXIT) begin
                        stop_flag = 1'b1;
                        state_d   = ST_HALT;
                    end else if (core.a7 == SVC_PRINT_INT) begin
                        disp_data_d = core.a0;
                    end
                end
            end
            ST_WAIT_PRESS: begin
                stop_flag = 1'b1;
                busy      = 1'b1;
                if (btn_press) begin
                    // Switches are sampled only at this edge
                    io_data_d = read_result(kind_q, sw_sync2_q);
                    state_d   = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                // Register file writes a0 and the PC advances at this edge
                io_wr_en = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_HALT: begin
                stop_flag = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            kind_q      <= RD_INT;
            io_data_q   <= 32'd0;
            disp_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            io_data_q   <= io_data_d;
            disp_data_q <= disp_data_d;
        end
    end

    assign core.stop_flag = stop_flag;
    assign core.io_wr_en  = io_wr_en;
    assign core.io_data   = io_data_q;
    assign disp_data      = disp_data_q;
    assign led_busy       = busy;

endmodule

// File: tb/tb_ecall_io_unit.sv
// Directed self-checking bench for ecall_io_unit with a 4-cycle debounce.
module tb_ecall_io_unit;

    logic        clk;
    logic        reset;
    logic [15:0] switches;
    logic        confirm_btn;
    logic [31:0] disp_data;
    logic        led_busy;

    int checks   = 0;
    int failures = 0;

    ecall_io_unit_if core_if ();

    ecall_io_unit #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .core        (core_if.slave),
        .switches    (switches),
        .confirm_btn (confirm_btn),
        .disp_data   (disp_data),
        .led_busy    (led_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Press the button at the next edge and hold it for 'hold' edges, waiting
    // at most 'budget' cycles for the write-back cycle. Returns at the negedge
    // inside the write-back cycle when it is seen.
    task automatic run_read(input int hold, input int budget,
                            output logic got, output logic [31:0] data);
        got  = 1'b0;
        data = 32'd0;
        confirm_btn = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (i + 1 == hold) confirm_btn = 1'b0;
            #1;
            if (core_if.io_wr_en === 1'b1) begin
                got  = 1'b1;
                data = core_if.io_data;
                break;
            end
        end
    endtask

    // Count write-back pulses over n cycles
    task automatic count_wr(input int n, output int wr_cnt);
        wr_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            if (core_if.io_wr_en === 1'b1) wr_cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        got;
        logic [31:0] data;
        int          wr_cnt;
        int          bad;

        reset = 1'b0;
        switches = 16'd0;
        confirm_btn = 1'b0;
        core_if.ecall_valid = 1'b0;
        core_if.a7 = 32'd0;
        core_if.a0 = 32'd0;

        // ---------------- reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_stop", core_if.stop_flag, 32'd0);
        check("rst_io_data", core_if.io_data, 32'd0);
        check("rst_wr_en", core_if.io_wr_en, 32'd0);
        check("rst_disp", disp_data, 32'd0);
        check("rst_busy", led_busy, 32'd0);
        reset = 1'b1;
        $display("TXN reset released");

        // ---------------- READ_INT with exact press latency
        switches = 16'hFFFE;
        repeat (3) @(negedge clk);
        core_if.ecall_valid = 1'b1;
        core_if.a7 = 32'd5;
        #1;
        check("ri_stall_first_cycle", core_if.stop_flag, 32'd1);
        check("ri_busy_first_cycle", led_busy, 32'd0);
        @(negedge clk);
        #1;
        check("ri_busy_wait", led_busy, 32'd1);
        check("ri_stall_wait", core_if.stop_flag, 32'd1);
        confirm_btn = 1'b1;                      // first sampled at E0
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            #1;
            check("ri_no_wr_before_e6", core_if.io_wr_en, 32'd0);
        end
        @(negedge clk);                          // cycle after E6
        #1;
        check("ri_wr_en", core_if.io_wr_en, 32'd1);
        check("ri_stop_low_in_wb", core_if.stop_flag, 32'd0);
        check("ri_io_data", core_if.io_data, 32'hFFFF_FFFE);
        check("ri_busy_wb", led_busy, 32'd0);
        @(negedge clk);                          // cycle after E7
        core_if.ecall_valid = 1'b0;
        #1;
        check("ri_wr_one_cycle", core_if.io_wr_en, 32'd0);
        check("ri_stop_after", core_if.stop_flag, 32'd0);
        $display("TXN read_int io_data=%h", core_if.io_data);
        repeat (2) @(negedge clk);
        confirm_btn = 1'b0;                      // held for E0..E9
        repeat (10) @(negedge clk);

        // ---------------- READ_CHAR
        switches = 16'h80C1;
        repeat (3) @(negedge clk);
        core_if.ecall_valid = 1'b1;
        core_if.a7 = 32'd12;
        run_read(6, 20, got, data);
        check("rc_completed", got, 32'd1);
        check("rc_io_data", data, 32'h0000_00C1);
        @(negedge clk);
        core_if.ecall_valid = 1'b0;
        $display("TXN read_char io_data=%h", data);
        repeat (10) @(negedge clk);

        // ---------------- Glitch rejection then real press
        switches = 16'h1234;
        repeat (3) @(negedge clk);
        core_if.ecall_valid = 1'b1;
        core_if.a7 = 32'd5;
        run_read(3, 15, got, data);
        check("gl_no_press", got, 32'd0);
        check("gl_busy_still", led_busy, 32'd1);
        check("gl_stall_still", core_if.stop_flag, 32'd1);
        run_read(6, 20, got, data);
        check("gl_completed", got, 32'd1);
        check("gl_io_data", data, 32'h0000_1234);
        @(negedge clk);
        core_if.ecall_valid = 1'b0;
        $display("TXN glitch_then_read io_data=%h", data);
        repeat (10) @(negedge clk);

        // ---------------- Button already held when ecall arrives
        confirm_btn = 1'b1;
        switches = 16'h0005;
        repeat (10) @(negedge clk);
        core_if.ecall_valid = 1'b1;
        core_if.a7 = 32'd5;
        count_wr(12, wr_cnt);
        check("held_no_wr", wr_cnt, 32'd0);
        confirm_btn = 1'b0;
        count_wr(10, wr_cnt);
        check("held_release_no_wr", wr_cnt, 32'd0);
        check("held_busy", led_busy, 32'd1);
        run_read(6, 20, got, data);
        check("held_repress_completed", got, 32'd1);
        check("held_io_data", data, 32'h0000_0005);
        @(negedge clk);
        core_if.ecall_valid = 1'b0;
        $display("TXN held_button io_data=%h", data);
        repeat (10) @(negedge clk);

        // ---------------- PRINT_INT
        core_if.ecall_valid = 1'b1;
        core_if.a7 = 32'd1;
        core_if.a0 = 32'h1234_5678;
        #1;
        check("pi_no_stall", core_if.stop_flag, 32'd0);
        @(negedge clk);
        #1;
        check("pi_disp", disp_data, 32'h1234_5678);
        check("pi_no_stall_after", core_if.stop_flag, 32'd0);
        core_if.ecall_valid = 1'b0;
        core_if.a0 = 32'd0;
        $display("TXN print_int disp=%h", disp_data);

        // ---------------- Unknown code
        @(negedge clk);
        core_if.ecall_valid = 1'b1;
        core_if.a7 = 32'd7;
        core_if.a0 = 32'hDEAD_BEEF;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (core_if.stop_flag !== 1'b0 || core_if.io_wr_en !== 1'b0 || led_busy !== 1'b0) bad++;
            @(negedge clk);
        end
        check("unk_no_stall_no_wr", bad, 32'd0);
        check("unk_disp_kept", disp_data, 32'h1234_5678);
        core_if.ecall_valid = 1'b0;
        $display("TXN unknown_code a7=%0d", core_if.a7);

        // ---------------- EXIT, then reset while halted
        @(negedge clk);
        core_if.ecall_valid = 1'b1;
        core_if.a7 = 32'd10;
        #1;
        check("ex_stall_first_cycle", core_if.stop_flag, 32'd1);
        @(negedge clk);
        core_if.ecall_valid = 1'b0;
        bad = 0;
        wr_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            confirm_btn = ((i % 20) < 10);
            #1;
            if (core_if.stop_flag !== 1'b1) bad++;
            if (core_if.io_wr_en === 1'b1) wr_cnt++;
            @(negedge clk);
        end
        check("ex_stall_100", bad, 32'd0);
        check("ex_no_wr", wr_cnt, 32'd0);
        confirm_btn = 1'b0;
        reset = 1'b0;
        #1;
        check("ex_rst_stop", core_if.stop_flag, 32'd0);
        check("ex_rst_disp", disp_data, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        $display("TXN exit_then_reset stop=%0d", core_if.stop_flag);
        repeat (3) @(negedge clk);

        // ---------------- Reset in the middle of WAIT_PRESS
        core_if.ecall_valid = 1'b1;
        core_if.a7 = 32'd5;
        @(negedge clk);
        confirm_btn = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rw_busy_before_rst", led_busy, 32'd1);
        check("rw_io_data_before_rst", core_if.io_data, 32'h0000_0000);
        reset = 1'b0;
        core_if.ecall_valid = 1'b0;
        #1;
        check("rw_rst_busy", led_busy, 32'd0);
        check("rw_rst_stop", core_if.stop_flag, 32'd0);
        count_wr(3, wr_cnt);
        reset = 1'b1;
        confirm_btn = 1'b0;
        begin
            int wr_more;
            count_wr(10, wr_more);
            check("rw_no_wr", wr_cnt + wr_more, 32'd0);
        end
        switches = 16'h8000;
        repeat (3) @(negedge clk);
        core_if.ecall_valid = 1'b1;
        core_if.a7 = 32'd5;
        run_read(6, 20, got, data);
        check("rw_next_completed", got, 32'd1);
        check("rw_next_io_data", data, 32'hFFFF_8000);
        @(negedge clk);
        core_if.ecall_valid = 1'b0;
        #1;
        check("rw_next_wr_done", core_if.io_wr_en, 32'd0);
        $display("TXN reset_mid_wait io_data=%h", data);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
